// File: rtl/one_ms_clk_divider.sv
// -----------------------------------------------------------------------------
// one_ms_clk_divider
//   Timebase for the top level: divides the board system clock down to a
//   square wave of OUT_PERIOD_US microseconds (1 ms by default). It also
//   provides a one-cycle tick at each out_clk rising edge and a free-running
//   count of completed periods. Consumers should use tick_1ms as a clock
//   enable; out_clk is meant for slow external or visual use.
//
// Parameters
//   IN_FREQ_HZ     frequency of in_clk in Hz
//   OUT_PERIOD_US  out_clk period in microseconds
//   MS_CNT_W       width of ms_count
//
// Ports
//   in_clk    in   1         system clock, all logic on its rising edge
//   rst_n     in   1         asynchronous active-low reset
//   out_clk   out  1         divided clock, registered, period DIV cycles
//   tick_1ms  out  1         one-cycle pulse aligned with each out_clk rise
//   ms_count  out  MS_CNT_W  completed periods since reset, wraps
// -----------------------------------------------------------------------------
module one_ms_clk_divider #(
  parameter int unsigned IN_FREQ_HZ    = 100_000_000,
  parameter int unsigned OUT_PERIOD_US = 1000,
  parameter int unsigned MS_CNT_W      = 16
) (
  input  logic                in_clk,
  input  logic                rst_n,
  output logic                out_clk,
  output logic                tick_1ms,
  output logic [MS_CNT_W-1:0] ms_count
);

  // Multiply before dividing, in 64 bits: the plain left-to-right form
  // truncates to zero for clocks below 1 MHz, and the product overflows
  // 32 bits at the default 100 MHz.
  localparam longint unsigned DIV_L =
    (64'(IN_FREQ_HZ) * 64'(OUT_PERIOD_US)) / 64'd1_000_000;
  localparam int unsigned DIV      = 32'(DIV_L);
  localparam int unsigned LOW_CYC  = DIV - DIV / 2;
  localparam int unsigned HIGH_CYC = DIV / 2;
  localparam int unsigned CNT_W    = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYC - 1);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("one_ms_clk_divider: divide ratio must be at least 2");
    end
  endgenerate

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise;

  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = cnt + 1'b1;
    rise      = 1'b0;
    case (phase)
      PH_LOW: begin
        if (cnt == LOW_LAST) begin
          phase_nxt = PH_HIGH;
          cnt_nxt   = '0;
          rise      = 1'b1;
        end
      end
      PH_HIGH: begin
        if (cnt == HIGH_LAST) begin
          phase_nxt = PH_LOW;
          cnt_nxt   = '0;
        end
      end
      default: begin
        phase_nxt = PH_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // out_clk and tick_1ms are registered from the next-state decode so both
  // change on the same in_clk edge and out_clk never sees combinational logic.
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= PH_LOW;
      cnt      <= '0;
      out_clk  <= 1'b0;
      tick_1ms <= 1'b0;
      ms_count <= '0;
    end else begin
      phase    <= phase_nxt;
      cnt      <= cnt_nxt;
      out_clk  <= (phase_nxt == PH_HIGH);
      tick_1ms <= rise;
      if (rise) begin
        ms_count <= ms_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_one_ms_clk_divider.sv
module tb_one_ms_clk_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_even, rst_odd, rst_wrap, rst_dflt;

  logic        even_out, even_tick;
  logic [15:0] even_cnt;
  logic        odd_out, odd_tick;
  logic [15:0] odd_cnt;
  logic        wrap_out, wrap_tick;
  logic [2:0]  wrap_cnt;
  logic        dflt_out, dflt_tick;
  logic [15:0] dflt_cnt;

  // DIV = 10
  one_ms_clk_divider #(.IN_FREQ_HZ(10_000), .OUT_PERIOD_US(1000), .MS_CNT_W(16)) u_even (
    .in_clk(clk), .rst_n(rst_even), .out_clk(even_out), .tick_1ms(even_tick), .ms_count(even_cnt));
  // DIV = 7
  one_ms_clk_divider #(.IN_FREQ_HZ(7_000), .OUT_PERIOD_US(1000), .MS_CNT_W(16)) u_odd (
    .in_clk(clk), .rst_n(rst_odd), .out_clk(odd_out), .tick_1ms(odd_tick), .ms_count(odd_cnt));
  // DIV = 4, 3-bit count
  one_ms_clk_divider #(.IN_FREQ_HZ(4_000), .OUT_PERIOD_US(1000), .MS_CNT_W(3)) u_wrap (
    .in_clk(clk), .rst_n(rst_wrap), .out_clk(wrap_out), .tick_1ms(wrap_tick), .ms_count(wrap_cnt));
  // DIV = 100_000
  one_ms_clk_divider u_dflt (
    .in_clk(clk), .rst_n(rst_dflt), .out_clk(dflt_out), .tick_1ms(dflt_tick), .ms_count(dflt_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  // Rising edges seen since each instance's reset was released.
  int unsigned n_even, n_odd, n_wrap, n_dflt;
  always @(posedge clk or negedge rst_even) if (!rst_even) n_even <= 0; else n_even <= n_even + 1;
  always @(posedge clk or negedge rst_odd)  if (!rst_odd)  n_odd  <= 0; else n_odd  <= n_odd + 1;
  always @(posedge clk or negedge rst_wrap) if (!rst_wrap) n_wrap <= 0; else n_wrap <= n_wrap + 1;
  always @(posedge clk or negedge rst_dflt) if (!rst_dflt) n_dflt <= 0; else n_dflt <= n_dflt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output values after n edges from reset release, from the timing rules:
  // high while (n mod DIV) is in the upper HIGH_CYC positions, a tick at each
  // n = LOW + k*DIV, and the count is the number of such ticks so far.
  function automatic void model(input int unsigned div, input int unsigned n, input int unsigned w,
                                output logic o, output logic t, output logic [63:0] c);
    int unsigned low;
    longint unsigned ticks;
    low   = div - div / 2;
    o     = (n % div) >= low;
    t     = (n >= 1) && ((n % div) == low);
    ticks = (n >= low) ? (longint'((n - low) / div) + 1) : 0;
    c     = 64'(ticks % (64'd1 << w));
  endfunction

  task automatic cmp_inst(input string tag, input int unsigned div, input int unsigned w,
                          input int unsigned n, input logic o, input logic t, input logic [63:0] c);
    logic eo, et;
    logic [63:0] ec;
    model(div, n, w, eo, et, ec);
    chk({tag, "_out_clk"},  64'(o), 64'(eo));
    chk({tag, "_tick_1ms"}, 64'(t), 64'(et));
    chk({tag, "_ms_count"}, c, ec);
  endtask

  logic prev_wrap_tick = 1'b0;
  logic prev_even_tick = 1'b0;

  always @(negedge clk) begin
    cmp_inst("even", 10, 16, n_even, even_out, even_tick, 64'(even_cnt));
    cmp_inst("odd",  7,  16, n_odd,  odd_out,  odd_tick,  64'(odd_cnt));
    cmp_inst("wrap", 4,  3,  n_wrap, wrap_out, wrap_tick, 64'(wrap_cnt));
    cmp_inst("dflt", 100_000, 16, n_dflt, dflt_out, dflt_tick, 64'(dflt_cnt));

    // Hand-computed points that pin the model.
    if (rst_even && n_even == 4)  chk("even_n4_low", 64'(even_out), 64'd0);
    if (rst_even && n_even == 5)  chk("even_n5_rise", 64'(even_out), 64'd1);
    if (rst_even && n_even == 5)  chk("even_n5_tick", 64'(even_tick), 64'd1);
    if (rst_even && n_even == 10) chk("even_n10_low", 64'(even_out), 64'd0);
    if (rst_even && n_even == 30) chk("even_n30_count", 64'(even_cnt), 64'd3);
    if (rst_odd && n_odd == 4)    chk("odd_n4_rise", 64'(odd_out), 64'd1);
    if (rst_odd && n_odd == 7)    chk("odd_n7_fall", 64'(odd_out), 64'd0);
    if (rst_odd && n_odd == 144)  chk("odd_n144_tick", 64'(odd_tick), 64'd1);
    if (rst_odd && n_odd == 144)  chk("odd_n144_count", 64'(odd_cnt), 64'd21);
    if (rst_wrap && n_wrap == 29) chk("wrap_n29_count7", 64'(wrap_cnt), 64'd7);
    if (rst_wrap && n_wrap == 30) chk("wrap_n30_count0", 64'(wrap_cnt), 64'd0);
    if (rst_wrap && n_wrap == 34) chk("wrap_n34_count1", 64'(wrap_cnt), 64'd1);
    if (rst_dflt && n_dflt == 49_999) chk("dflt_n49999_low", 64'(dflt_out), 64'd0);
    if (rst_dflt && n_dflt == 50_000) chk("dflt_n50000_rise", 64'(dflt_out), 64'd1);
    if (rst_dflt && n_dflt == 50_000) chk("dflt_n50000_count", 64'(dflt_cnt), 64'd1);

    if (wrap_tick) chk("wrap_tick_width", 64'(prev_wrap_tick), 64'd0);
    if (even_tick) chk("even_tick_width", 64'(prev_even_tick), 64'd0);
    prev_wrap_tick = wrap_tick;
    prev_even_tick = even_tick;
  end

  initial begin
    rst_even = 1'b0;
    rst_odd  = 1'b0;
    rst_wrap = 1'b0;
    rst_dflt = 1'b0;

    // Reset held for 5 cycles; also sample just after rising edges.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_even_out", 64'(even_out), 64'd0);
      chk("rst_even_tick", 64'(even_tick), 64'd0);
      chk("rst_even_cnt", 64'(even_cnt), 64'd0);
      chk("rst_dflt_out", 64'(dflt_out), 64'd0);
      chk("rst_wrap_cnt", 64'(wrap_cnt), 64'd0);
    end
    @(negedge clk);
    #2;
    rst_even = 1'b1;
    rst_odd  = 1'b1;
    rst_wrap = 1'b1;
    rst_dflt = 1'b1;

    // Third cycle of the fifth high phase of u_even (high at n = 45..49).
    while (n_even != 47) @(negedge clk);
    #2;
    rst_even = 1'b0;
    #1;
    chk("midrst_out", 64'(even_out), 64'd0);
    chk("midrst_tick", 64'(even_tick), 64'd0);
    chk("midrst_cnt", 64'(even_cnt), 64'd0);
    @(negedge clk);
    #2;
    rst_even = 1'b1;

    while (n_dflt < 50_010) @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
